// File: rtl/store_align.sv
// store_align: places a byte/half/word store onto the lanes of a 32-bit
// word-addressed write bus. It generates byte enables and splits misaligned
// stores into two beats.
//
//   state | meaning
//   IDLE  | ready for a new store request
//   BEAT0 | first (or only) bus beat presented, waiting for bus_ready
//   BEAT1 | second beat of a split store, waiting for bus_ready
module store_align #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_data,
  input  logic [1:0]            req_size,
  output logic                  bus_valid,
  input  logic                  bus_ready,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [31:0]           bus_wdata,
  output logic [3:0]            bus_be,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  state_t                state, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [31:0]           data_q, data_d;
  logic [1:0]            off_q, off_d;
  logic [3:0]            mask_q, mask_d;
  logic                  split_q, split_d;

  logic                  bus_valid_d;
  logic [ADDR_WIDTH-1:0] bus_addr_d;
  logic [31:0]           bus_wdata_d;
  logic [3:0]            bus_be_d;
  logic                  done_d, err_d;

  logic                  accept;
  logic [1:0]            req_off;
  logic [3:0]            req_mask;
  logic                  req_split;
  logic [ADDR_WIDTH-1:0] req_base;
  logic [5:0]            hi_shift;

  // req_ready depends on rst_n directly so nothing is accepted during reset.
  assign req_ready = (state == IDLE) && rst_n;
  assign accept    = req_valid && req_ready;
  assign req_off   = req_addr[1:0];
  assign req_base  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
  // Second-beat shift is 8*(4-off) bits; off is 1..3 whenever a split happens.
  assign hi_shift  = 6'd32 - {1'b0, off_q, 3'b000};

  // Decode size into a lane mask and whether the store crosses a word boundary.
  always_comb begin
    req_mask  = 4'b0000;
    req_split = 1'b0;
    case (req_size)
      2'b00: req_mask = 4'b0001;
      2'b01: begin
        req_mask  = 4'b0011;
        req_split = (req_off == 2'd3);
      end
      2'b10: begin
        req_mask  = 4'b1111;
        req_split = (req_off != 2'd0);
      end
      default: req_mask = 4'b0000;
    endcase
  end

  // Next-state logic; bus outputs are computed here and registered below.
  always_comb begin
    state_d     = state;
    base_d      = base_q;
    data_d      = data_q;
    off_d       = off_q;
    mask_d      = mask_q;
    split_d     = split_q;
    bus_valid_d = bus_valid;
    bus_addr_d  = bus_addr;
    bus_wdata_d = bus_wdata;
    bus_be_d    = bus_be;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_size == 2'b11) begin
            err_d = 1'b1;
          end else begin
            state_d     = BEAT0;
            base_d      = req_base;
            data_d      = req_data;
            off_d       = req_off;
            mask_d      = req_mask;
            split_d     = req_split;
            bus_valid_d = 1'b1;
            bus_addr_d  = req_base;
            bus_wdata_d = req_data << {req_off, 3'b000};
            bus_be_d    = req_mask << req_off;
          end
        end
      end
      BEAT0: begin
        if (bus_ready) begin
          if (split_q) begin
            state_d     = BEAT1;
            bus_addr_d  = base_q + ADDR_WIDTH'(4);
            bus_wdata_d = data_q >> hi_shift;
            bus_be_d    = mask_q >> (3'd4 - {1'b0, off_q});
          end else begin
            state_d     = IDLE;
            bus_valid_d = 1'b0;
            done_d      = 1'b1;
          end
        end
      end
      BEAT1: begin
        if (bus_ready) begin
          state_d     = IDLE;
          bus_valid_d = 1'b0;
          done_d      = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, captured request and registered bus outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      base_q    <= '0;
      data_q    <= '0;
      off_q     <= '0;
      mask_q    <= '0;
      split_q   <= 1'b0;
      bus_valid <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_be    <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      base_q    <= base_d;
      data_q    <= data_d;
      off_q     <= off_d;
      mask_q    <= mask_d;
      split_q   <= split_d;
      bus_valid <= bus_valid_d;
      bus_addr  <= bus_addr_d;
      bus_wdata <= bus_wdata_d;
      bus_be    <= bus_be_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

endmodule

// File: doc/store_align.md
# store_align

Store-path data aligner for the load/store unit: the write-direction counterpart of the load-side sign extension. It takes a register value plus byte/half/word size and a byte address, places the value on the correct byte lanes of a 32-bit word-addressed data bus, and generates byte enables. Misaligned stores are split into two bus beats by a small FSM with valid/ready handshakes on both sides. It sits between the execute stage store request and the data-memory write port.

## Interface

- ADDR_WIDTH, 32, byte address width; bus addresses are word aligned (bits [1:0] = 0).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  store request present.
- req_ready  out  1  block can accept a request.
- req_addr  in  ADDR_WIDTH  byte address of the store.
- req_data  in  32  store source register; only the low 8/16/32 bits are used.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- bus_valid  out  1  write beat present.
- bus_ready  in  1  memory accepts the beat.
- bus_addr  out  ADDR_WIDTH  word-aligned beat address.
- bus_wdata  out  32  lane-placed write data.
- bus_be  out  4  byte enables; bit i enables bus_wdata[8i+7:8i].
- done  out  1  one-cycle pulse: store fully written.
- err  out  1  one-cycle pulse: reserved size rejected.

## Operation

- States: IDLE, BEAT0, BEAT1. req_ready = 1 only in IDLE with rst_n high.
- Accept on req_valid && req_ready; addr, data and size are registered. Inputs are ignored outside IDLE.
- off = addr[1:0]; mask = 0001 (byte), 0011 (half), 1111 (word); base = addr with [1:0] cleared.
- Split when off + bytes > 4: half at off 3; word at off 1, 2 or 3. Bytes never split.
- BEAT0: bus_addr = base, bus_wdata = data << 8*off, bus_be = (mask << off)[3:0].
- BEAT1 (split only): bus_addr = base + 4, modulo 2^ADDR_WIDTH, so 0xFFFFFFFC wraps to 0x00000000. bus_wdata = data >> 8*(4-off), bus_be = mask >> (4-off).
- Transitions:
  - IDLE to BEAT0 on accept with size != 11.
  - BEAT0 to BEAT1 on handshake if split, else to IDLE.
  - BEAT1 to IDLE on handshake.
- Reserved size: no bus beat, stay in IDLE, err pulses next cycle.
- Unused lanes (be = 0) in bus_wdata carry don't-care data. The verifier checks enabled lanes only.
- While bus_valid is high and bus_ready is low, bus_addr, bus_wdata and bus_be hold stable.

## Timing

- Reset (rst_n low at an edge): state IDLE. bus_valid, bus_addr, bus_wdata, bus_be, done and err all 0. req_ready is 0 while rst_n is low.
- Reset mid-operation: the beat is abandoned, bus_valid is 0 after that edge, and no done pulse is issued.
- Accept at edge N: bus_valid is high in cycle N+1. All bus outputs are registered.
- Aligned store with bus_ready held high: handshake in N+1, done and req_ready high in N+2. Throughput is one store per 2 cycles.
- Split store with bus_ready held high: beats in N+1 and N+2, done in N+3.
- done is registered and asserts the cycle after the final beat handshake, coinciding with the return to IDLE. A new request can be accepted in the same cycle done is high.
- err pulses in N+1 for a reserved-size accept. req_ready stays high throughout.
- Each cycle of bus_ready low extends latency by exactly one cycle.

## Test plan

- Byte store: addr 0x1003, data 0xAABBCCDD, size 00 -> one beat: addr 0x1000, be 1000, wdata[31:24] = 0xDD; done 2 cycles after accept.
- Aligned word: addr 0x2000, data 0x12345678, size 10, bus_ready held low 3 cycles -> one beat: addr 0x2000, be 1111, wdata 0x12345678, outputs stable while stalled; done follows the handshake.
- Misaligned half: addr 0x3003, data 0x0000BEEF, size 01 -> beat 1: addr 0x3000, be 1000, lane3 = 0xEF. Beat 2: addr 0x3004, be 0001, lane0 = 0xBE. Single done.
- Misaligned word with wrap: addr 0xFFFFFFFE, data 0xCAFEF00D -> beat 1: 0xFFFFFFFC, be 1100, lanes3:2 = 0xF00D. Beat 2: 0x00000000, be 0011, lanes1:0 = 0xCAFE.
- Reserved size 11 at addr 0x4000 -> no bus_valid, err pulse 1 cycle, req_ready stays 1. Next valid request is then accepted normally.
- Reset asserted during BEAT1 of a split store -> bus_valid 0 next cycle, no done. After release, req_ready is 1 and a new store completes correctly.
